// File: rtl/sonar_scan_scheduler.sv
// Round-robin scheduler that shares one sonar ranging engine across N_SENSORS
// sensors: start/ready handshake, per-phase timeouts, abort, echo-decay holdoff.
module sonar_scan_scheduler #(
    parameter int N_SENSORS      = 4,
    parameter int SEL_W          = 2,
    parameter int CNT_W          = 20,
    parameter int ACK_TIMEOUT    = 16,
    parameter int MEAS_TIMEOUT   = 400000,
    parameter int HOLDOFF_CYCLES = 600000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [N_SENSORS-1:0] enable_mask,
    input  logic                 meas_ready,
    input  logic [7:0]           meas_inches,
    output logic [SEL_W-1:0]     sensor_sel,
    output logic                 meas_start,
    output logic                 meas_abort,
    output logic                 result_valid,
    output logic [SEL_W-1:0]     result_sensor,
    output logic [7:0]           result_inches,
    output logic                 result_timeout,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_ARM,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_ABORT,
        S_HOLDOFF
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [SEL_W-1:0]   sensor_sel_q, sensor_sel_d;
    logic               meas_start_q, meas_start_d;
    logic               meas_abort_q, meas_abort_d;
    logic               result_valid_q, result_valid_d;
    logic [SEL_W-1:0]   result_sensor_q, result_sensor_d;
    logic [7:0]         result_inches_q, result_inches_d;
    logic               result_timeout_q, result_timeout_d;
    logic               busy_q, busy_d;

    logic [SEL_W-1:0]   next_sel;
    logic               next_found;
    logic               can_scan;

    assign can_scan = run && (enable_mask != '0);

    // First enabled sensor after the last serviced one, wrapping modulo N_SENSORS.
    always_comb begin
        next_sel   = last_q;
        next_found = 1'b0;
        for (int k = 1; k <= N_SENSORS; k++) begin
            if (!next_found && enable_mask[SEL_W'((int'(last_q) + k) % N_SENSORS)]) begin
                next_sel   = SEL_W'((int'(last_q) + k) % N_SENSORS);
                next_found = 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d          = state_q;
        last_d           = last_q;
        sensor_sel_d     = sensor_sel_q;
        meas_start_d     = 1'b0;
        result_valid_d   = 1'b0;
        result_sensor_d  = result_sensor_q;
        result_inches_d  = result_inches_q;
        result_timeout_d = result_timeout_q;

        case (state_q)
            S_IDLE: begin
                if (can_scan) begin
                    state_d      = S_SELECT;
                    sensor_sel_d = next_sel;
                end
            end
            S_SELECT: state_d = S_ARM;
            S_ARM: begin
                if (meas_ready) begin
                    state_d      = S_WAIT_ACK;
                    meas_start_d = 1'b1;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT)) begin
                    state_d = S_ABORT;
                end
            end
            S_WAIT_ACK: begin
                if (!meas_ready) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT)) begin
                    state_d = S_ABORT;
                end
            end
            S_WAIT_DONE: begin
                // A ready arriving on the timeout cycle still counts as a good result.
                if (meas_ready) begin
                    state_d          = S_HOLDOFF;
                    result_valid_d   = 1'b1;
                    result_sensor_d  = sensor_sel_q;
                    result_inches_d  = meas_inches;
                    result_timeout_d = 1'b0;
                    last_d           = sensor_sel_q;
                end else if (cnt_q == CNT_W'(MEAS_TIMEOUT)) begin
                    state_d = S_ABORT;
                end
            end
            S_ABORT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d          = S_HOLDOFF;
                    result_valid_d   = 1'b1;
                    result_sensor_d  = sensor_sel_q;
                    result_inches_d  = 8'hFF;
                    result_timeout_d = 1'b1;
                    last_d           = sensor_sel_q;
                end
            end
            S_HOLDOFF: begin
                if (cnt_q == CNT_W'(HOLDOFF_CYCLES - 1)) begin
                    if (can_scan) begin
                        state_d      = S_SELECT;
                        sensor_sel_d = next_sel;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        meas_abort_d = (state_d == S_ABORT);
        busy_d       = (state_d != S_IDLE);
        cnt_d        = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
    end

    // NOTE: state is updated only here and only with non-blocking assignments,
    // so every flop samples the values settled by the combinational block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            cnt_q            <= '0;
            last_q           <= SEL_W'(N_SENSORS - 1);
            sensor_sel_q     <= '0;
            meas_start_q     <= 1'b0;
            meas_abort_q     <= 1'b0;
            result_valid_q   <= 1'b0;
            result_sensor_q  <= '0;
            result_inches_q  <= '0;
            result_timeout_q <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            last_q           <= last_d;
            sensor_sel_q     <= sensor_sel_d;
            meas_start_q     <= meas_start_d;
            meas_abort_q     <= meas_abort_d;
            result_valid_q   <= result_valid_d;
            result_sensor_q  <= result_sensor_d;
            result_inches_q  <= result_inches_d;
            result_timeout_q <= result_timeout_d;
            busy_q           <= busy_d;
        end
    end

    assign sensor_sel     = sensor_sel_q;
    assign meas_start     = meas_start_q;
    assign meas_abort     = meas_abort_q;
    assign result_valid   = result_valid_q;
    assign result_sensor  = result_sensor_q;
    assign result_inches  = result_inches_q;
    assign result_timeout = result_timeout_q;
    assign busy           = busy_q;

endmodule
